// File: rtl/sifh_zoom_ctrl_pkg.sv
// sifh_zoom_ctrl_pkg: shared widths, bin-shift width helper and FSM encoding
// for the SiFH successive-zoom ranging sequencer.
package sifh_zoom_ctrl_pkg;
    localparam int NP_DEF = 16;
    localparam int NB_DEF = 5;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_PEAK, S_CALC, S_NEXT, S_DONE} state_t;
    function automatic int shift_w(input int np);
        return $clog2(np + 1);
    endfunction
endpackage

// File: rtl/sifh_frame_counter.sv
// sifh_frame_counter: clearable, enabled frame counter; tc flags the enabled
// cycle carrying the COUNT-th event.
module sifh_frame_counter #(
    parameter int COUNT = 1024,
    parameter int W = $clog2(COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] cnt_d, cnt_q;
    assign tc = en && (cnt_q == W'(COUNT - 1));
    always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/sifh_zoom_ctrl.sv
// sifh_zoom_ctrl: SiFH zoom-histogram ranging sequencer (start -> NSTAGE passes -> tof).
// Optional SIFH_PEAK_TIMEOUT_EN bounds the wait for the peak finder.
module sifh_zoom_ctrl
    import sifh_zoom_ctrl_pkg::*;
#(
    parameter int NP = NP_DEF,
    parameter int NB = NB_DEF,
    parameter int NSTAGE = 3,
    parameter int FRAMES = 1024,
    parameter int SHIFT_STEP = 4,
    parameter int PEAK_TIMEOUT = 255,
    localparam int SW = shift_w(NP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          frame_tick,
    output logic          busy,
    output logic          hist_clear,
    output logic          hist_en,
    output logic [NP-1:0] win_lo,
    output logic [NP-1:0] win_hi,
    output logic [SW-1:0] bin_shift,
    output logic [2:0]    stage,
    output logic          peak_req,
    input  logic          peak_valid,
    input  logic [NB-1:0] peak_ch,
    output logic [NB-1:0] alg_peak_ch,
    input  logic [NP-1:0] alg_th_minus,
    input  logic [NP-1:0] alg_th_positive,
    output logic          tof_valid,
    output logic [NP-1:0] tof,
    output logic          err
);
    state_t state_d, state_q;
    logic [NP-1:0] win_lo_d, win_lo_q, win_hi_d, win_hi_q, tof_d, tof_q;
    logic [SW-1:0] shift_d, shift_q;
    logic [2:0] stage_d, stage_q;
    logic [NB-1:0] peak_d, peak_q;
    logic err_d, err_q, fc_tc;

    assign busy = state_q != S_IDLE;
    assign hist_clear = state_q == S_CLEAR;
    assign hist_en = state_q == S_ACCUM;
    assign peak_req = state_q == S_PEAK;
    assign tof_valid = state_q == S_DONE;
    assign win_lo = win_lo_q;
    assign win_hi = win_hi_q;
    assign bin_shift = shift_q;
    assign stage = stage_q;
    assign alg_peak_ch = peak_q;
    assign tof = tof_q;
    assign err = err_q;

    sifh_frame_counter #(.COUNT(FRAMES)) u_frame_counter (
        .clk(clk),
        .rst(rst),
        .clr(state_q != S_ACCUM),
        .en(hist_en && frame_tick),
        .tc(fc_tc)
    );

`ifdef SIFH_PEAK_TIMEOUT_EN
    localparam int TW = $clog2(PEAK_TIMEOUT + 1);
    logic [TW-1:0] to_d, to_q;
    assign to_d = (state_q == S_PEAK) ? to_q + TW'(1) : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) to_q <= '0;
        else to_q <= to_d;
`endif

    always_comb begin
        state_d = state_q;
        win_lo_d = win_lo_q;
        win_hi_d = win_hi_q;
        shift_d = shift_q;
        stage_d = stage_q;
        peak_d = peak_q;
        tof_d = tof_q;
        err_d = err_q;
        unique case (state_q)
            S_IDLE: if (start && !abort) state_d = S_CLEAR;
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: if (fc_tc) state_d = S_PEAK;
            S_PEAK: begin
                if (peak_valid) begin
                    peak_d = peak_ch;
                    state_d = S_CALC;
                end
`ifdef SIFH_PEAK_TIMEOUT_EN
                else if (to_q == TW'(PEAK_TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    tof_d = '0;
                    state_d = S_DONE;
                end
`endif
            end
            S_CALC: begin
                if (stage_q == 3'(NSTAGE - 1)) begin
                    tof_d = win_lo_q + (NP'(peak_q) << shift_q) + ((NP'(1) << shift_q) >> 1);
                    state_d = S_DONE;
                end else if (alg_th_minus >= alg_th_positive) begin
                    err_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    win_lo_d = alg_th_minus;
                    win_hi_d = alg_th_positive;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                stage_d = stage_q + 3'd1;
                shift_d = (shift_q > SW'(SHIFT_STEP)) ? shift_q - SW'(SHIFT_STEP) : '0;
                state_d = S_CLEAR;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        // every return to IDLE re-arms the full-range first pass
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            win_lo_d = '0;
            win_hi_d = '1;
            shift_d = SW'(NP - NB);
            stage_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            win_lo_q <= '0;
            win_hi_q <= '1;
            shift_q <= SW'(NP - NB);
            stage_q <= '0;
            peak_q <= '0;
            tof_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_lo_q <= win_lo_d;
            win_hi_q <= win_hi_d;
            shift_q <= shift_d;
            stage_q <= stage_d;
            peak_q <= peak_d;
            tof_q <= tof_d;
            err_q <= err_d;
        end
endmodule

// File: tb/tb_sifh_zoom_ctrl.sv
// tb_sifh_zoom_ctrl: table-driven and randomized measurements against a
// pass-by-pass arithmetic model of the zoom sequence.
module tb_sifh_zoom_ctrl;
    localparam int NP = 16, NB = 5, NSTAGE = 3, FRAMES = 4, TMO = 10;

    logic clk = 1'b0, rst, start, abort, frame_tick, peak_valid;
    logic [NB-1:0] peak_ch, alg_peak_ch;
    logic [NP-1:0] alg_th_minus, alg_th_positive, win_lo, win_hi, tof;
    logic [4:0] bin_shift;
    logic [2:0] stage;
    logic busy, hist_clear, hist_en, peak_req, tof_valid, err;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    sifh_zoom_ctrl #(.NP(NP), .NB(NB), .NSTAGE(NSTAGE), .FRAMES(FRAMES), .PEAK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_tick(frame_tick),
        .busy(busy), .hist_clear(hist_clear), .hist_en(hist_en), .win_lo(win_lo), .win_hi(win_hi),
        .bin_shift(bin_shift), .stage(stage), .peak_req(peak_req), .peak_valid(peak_valid),
        .peak_ch(peak_ch), .alg_peak_ch(alg_peak_ch), .alg_th_minus(alg_th_minus),
        .alg_th_positive(alg_th_positive), .tof_valid(tof_valid), .tof(tof), .err(err)
    );

    typedef struct packed {
        logic [2:0][4:0]  pk;
        logic [1:0][15:0] thm;
        logic [1:0][15:0] thp;
        logic             exp_err;
        logic [15:0]      exp_tof;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic vec_t mk(input int p0, p1, p2, m0, q0, m1, q1, input logic e, input int t);
        vec_t v;
        v.pk[0] = 5'(p0); v.pk[1] = 5'(p1); v.pk[2] = 5'(p2);
        v.thm[0] = 16'(m0); v.thp[0] = 16'(q0); v.thm[1] = 16'(m1); v.thp[1] = 16'(q1);
        v.exp_err = e; v.exp_tof = 16'(t);
        return v;
    endfunction

    // Spec-level model: each pass either narrows to [THminus, THpositive] or ends the run.
    function automatic void model(inout vec_t v);
        int lo = 0, bs = NP - NB;
        v.exp_err = 1'b0;
        v.exp_tof = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            if (s == NSTAGE - 1) begin
                v.exp_tof = 16'((lo + int'(v.pk[s]) * (1 << bs) + (1 << bs) / 2) % 65536);
            end else if (v.thm[s] >= v.thp[s]) begin
                v.exp_err = 1'b1;
                break;
            end else begin
                lo = int'(v.thm[s]);
                bs = (bs > 4) ? bs - 4 : 0;
            end
        end
    endfunction

    task automatic run(input vec_t v, input int abort_stage, input bit respond);
        logic [15:0] elo[3], ehi[3];
        int ebs[3], npass, clears = 0, ticks = 0, tv = 0, wait_c = 0, entry = 0;
        bit in_peak = 0, done = 0, aborted = 0, finished = 0;
        elo[0] = '0; ehi[0] = 16'hffff; ebs[0] = NP - NB; npass = NSTAGE;
        for (int s = 0; s < NSTAGE - 1; s++) begin
            if (v.thm[s] >= v.thp[s]) begin
                npass = s + 1;
                break;
            end
            elo[s+1] = v.thm[s]; ehi[s+1] = v.thp[s];
            ebs[s+1] = (ebs[s] > 4) ? ebs[s] - 4 : 0;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
            start = 1'b0; abort = 1'b0; peak_valid = 1'b0; frame_tick = 1'b0;
            peak_ch = 5'($urandom);
            alg_th_minus = v.thm[stage == 3'd1];
            alg_th_positive = v.thp[stage == 3'd1];
            if (done || aborted) begin
                chk("busy_drop", 32'(busy), 0);
                chk("hist_en_drop", 32'(hist_en), 0);
                chk("peak_req_drop", 32'(peak_req), 0);
                finished = 1;
            end else begin
                if ($urandom_range(0, 5) == 0) start = 1'b1;
                if (hist_clear) begin
                    chk("pass_within_bound", 32'(clears < npass), 1);
                    if (clears < npass) begin
                        chk("pass_stage", 32'(stage), 32'(clears));
                        chk("pass_win_lo", 32'(win_lo), 32'(elo[clears]));
                        chk("pass_win_hi", 32'(win_hi), 32'(ehi[clears]));
                        chk("pass_bin_shift", 32'(bin_shift), 32'(ebs[clears]));
                    end
                    clears++;
                    ticks = 0;
                end
                if (hist_en) begin
                    frame_tick = 1'($urandom_range(0, 1));
                    if (frame_tick) ticks++;
                    if ($urandom_range(0, 3) == 0) peak_valid = 1'b1;
                    if (int'(stage) == abort_stage && ticks == 2) begin
                        abort = 1'b1;
                        aborted = 1;
                    end
                end else frame_tick = 1'($urandom_range(0, 1));
                if (peak_req) begin
                    if (!in_peak) begin
                        in_peak = 1;
                        entry = cyc;
                        chk("ticks_per_pass", 32'(ticks), FRAMES);
                        wait_c = $urandom_range(0, 3);
                    end
                    if (respond) begin
                        if (wait_c == 0) begin
                            peak_valid = 1'b1;
                            peak_ch = v.pk[stage[1:0]];
                        end else wait_c--;
                    end else if (cyc - entry == 300) begin
                        chk("stall_busy", 32'(busy), 1);
                        chk("stall_no_tof", 32'(tv), 0);
                        abort = 1'b1;
                        aborted = 1;
                    end
                end else in_peak = 0;
                if (tof_valid) begin
                    tv++;
                    done = 1;
                    if (respond) begin
                        chk("err", 32'(err), 32'(v.exp_err));
                        if (!v.exp_err) chk("tof", 32'(tof), 32'(v.exp_tof));
                        chk("alg_peak_ch", 32'(alg_peak_ch), 32'(v.pk[npass-1]));
                        chk("pass_count", 32'(clears), 32'(npass));
                    end else begin
                        chk("timeout_latency", 32'(cyc - entry), TMO);
                        chk("timeout_err", 32'(err), 1);
                        chk("timeout_tof", 32'(tof), 0);
                    end
                end
            end
            @(negedge clk);
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL run_budget: measurement did not complete within cycle budget");
        end
        start = 1'b0; abort = 1'b0; peak_valid = 1'b0; frame_tick = 1'b0;
        repeat (3) begin
            if (tof_valid) tv++;
            @(negedge clk);
        end
        chk("busy_idle", 32'(busy), 0);
`ifdef SIFH_PEAK_TIMEOUT_EN
        chk("tof_valid_count", 32'(tv), (aborted && respond) ? 0 : 1);
`else
        chk("tof_valid_count", 32'(tv), aborted ? 0 : 1);
`endif
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        tbl[0] = mk(3, 17, 5, 'h2000, 'h3000, 'h2400, 'h2800, 1'b0, 'h242C);
        tbl[1] = mk(9, 0, 0, 'h3000, 'h2000, 0, 0, 1'b1, 0);
        tbl[2] = mk(4, 8, 0, 'h1000, 'h9000, 'h5000, 'h5000, 1'b1, 0);
        tbl[3] = mk(31, 31, 31, 'hFF00, 'hFFFF, 'hFFF0, 'hFFFF, 1'b0, 'h00EC);
        tbl[4] = mk(0, 0, 0, 0, 'hFFFF, 0, 1, 1'b0, 4);
        rst = 1'b1; start = 1'b0; abort = 1'b0; frame_tick = 1'b0; peak_valid = 1'b0;
        peak_ch = '0; alg_th_minus = '0; alg_th_positive = '0;
        #2;
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_win_hi", 32'(win_hi), 'hffff);
        repeat (2) @(negedge clk);
        chk("rst_win_lo", 32'(win_lo), 0);
        chk("rst_bin_shift", 32'(bin_shift), NP - NB);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_outs", 32'({hist_clear, hist_en, peak_req, tof_valid, err}), 0);
        chk("rst_tof", 32'(tof), 0);
        chk("rst_alg_peak_ch", 32'(alg_peak_ch), 0);
        rst = 1'b0;
        @(negedge clk);
`ifndef SIFH_PEAK_TIMEOUT_EN
        for (int i = 0; i < 5; i++) run(tbl[i], -1, 1'b1);
`else
        for (int i = 0; i < 5; i++) run(tbl[i], -1, 1'b1);
`endif
        run(tbl[0], 1, 1'b1);
        run(tbl[0], -1, 1'b1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (3) begin
            chk("start_abort_idle", 32'({busy, hist_clear}), 0);
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            rv = mk($urandom, $urandom, $urandom, 0, 0, 0, 0, 1'b0, 0);
            for (int s = 0; s < 2; s++) begin
                rv.thm[s] = 16'($urandom);
                rv.thp[s] = 16'($urandom);
                if ($urandom_range(0, 4) != 0 && rv.thm[s] > rv.thp[s]) begin
                    rv.thm[s] = rv.thp[s] ^ rv.thm[s];
                    rv.thp[s] = rv.thp[s] ^ rv.thm[s];
                    rv.thm[s] = rv.thp[s] ^ rv.thm[s];
                end
            end
            model(rv);
            run(rv, -1, 1'b1);
        end
        run(tbl[0], -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sifh_zoom_ctrl.md
Name: sifh_zoom_ctrl

Overview:
Sequencer for the SiFH (successive zoom histogram) ranging loop; one `start` produces one `tof` result.
- Runs NSTAGE histogram passes, starting with the full TDC range.
- After each pass it presents the histogram peak bin to algebraicBlock.
- It registers the returned THminus/THpositive as the next pass's time window, then narrows the bin width.
- Sits between the laser/frame timing, the histogram+peak-finder, and algebraicBlock.

Parameters:
NP, 16, TDC timestamp width (matches `Np`).
NB, 5, histogram bin-index width (matches `Nb`).
NSTAGE, 3, zoom passes per measurement (1..8).
FRAMES, 1024, laser frames accumulated per pass.
SHIFT_STEP, 4, bin_shift decrement per stage; floored at 0.
PEAK_TIMEOUT, 255, max cycles to wait for peak_valid (used only when the optional feature is enabled).

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  one-cycle measurement request
abort  in  1  one-cycle abort
frame_tick  in  1  one pulse per laser frame
busy  out  1  high from accepted start until done
hist_clear  out  1  one-cycle histogram clear
hist_en  out  1  histogram accumulate enable
win_lo  out  NP  window lower bound (inclusive)
win_hi  out  NP  window upper bound (inclusive)
bin_shift  out  $clog2(NP+1)  bin index = (ts - win_lo) >> bin_shift
stage  out  3  current pass index
peak_req  out  1  level request to peak finder
peak_valid  in  1  peak finder result strobe
peak_ch  in  NB  peak bin index
alg_peak_ch  out  NB  registered peak bin driven to algebraicBlock
alg_th_minus  in  NP  algebraicBlock THminus
alg_th_positive  in  NP  algebraicBlock THpositive
tof_valid  out  1  one-cycle result strobe
tof  out  NP  result timestamp
err  out  1  result invalid; valid with tof_valid

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0, except:
  - win_hi = all-ones
  - bin_shift = NP-NB
  - state = IDLE
- FSM states: IDLE, CLEAR, ACCUM, PEAK, CALC, NEXT, DONE.
- IDLE:
  - start → CLEAR.
  - On entry: win_lo = 0, win_hi = all-ones, bin_shift = NP-NB, stage = 0, frame counter = 0, err = 0.
  - busy = 1 from the cycle after start.
- CLEAR: hist_clear = 1 for exactly one cycle → ACCUM.
- ACCUM:
  - hist_en = 1.
  - Frame counter increments on each frame_tick.
  - The FRAMES-th tick is still accumulated; the next cycle → PEAK with hist_en = 0.
  - frame_tick outside ACCUM is ignored.
- PEAK:
  - peak_req = 1 until peak_valid.
  - On peak_valid: alg_peak_ch <= peak_ch → CALC.
  - peak_valid in any other state is ignored.
- CALC:
  - One settle cycle for the combinational algebraicBlock.
  - If stage == NSTAGE-1: tof <= win_lo + (alg_peak_ch << bin_shift) + half-bin, where half-bin = (1 << bin_shift) >> 1. → DONE.
  - Else if alg_th_minus >= alg_th_positive: err <= 1 → DONE.
  - Else: win_lo <= alg_th_minus, win_hi <= alg_th_positive → NEXT.
- NEXT:
  - stage += 1.
  - bin_shift <= (bin_shift > SHIFT_STEP) ? bin_shift - SHIFT_STEP : 0.
  - Frame counter cleared → CLEAR.
- DONE: tof_valid = 1 for one cycle; busy = 0 next cycle → IDLE.
- start while busy: ignored.
- abort in any non-IDLE state: next cycle → IDLE.
  - hist_en, peak_req and busy are deasserted.
  - No tof_valid is issued.
- abort and start in the same cycle from IDLE: abort wins; stays IDLE.
- Arithmetic: tof addition is NP bits and wraps modulo 2^NP; window clamping is algebraicBlock's job.
- Latency: total pass cycles + 1 CALC cycle per stage + NEXT/CLEAR overhead (2 cycles per stage transition).

Optional Feature:
SIFH_PEAK_TIMEOUT_EN.
- Defined: a cycle counter runs in PEAK. If it reaches PEAK_TIMEOUT without peak_valid: err <= 1, tof <= 0 → DONE (tof_valid pulses with err = 1).
- Undefined: PEAK waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package/header (parametersSiFH.vh):
  - NP/NB defaults
  - FSM state encoding constants
  - bin_shift width localparam
- Sub-module sifh_frame_counter: clearable, enabled frame counter with terminal-count flag, reused by future capture blocks.
- algebraicBlock stays external.

Test Plan:
1. NSTAGE=1, FRAMES=4, peak_ch=5 after 2 cycles → one hist_clear, hist_en for exactly 4 ticks, tof = (5<<11) + 1024 = 11264, err = 0.
2. NSTAGE=3, THminus/THpositive stubbed to 0x2000/0x3000 then 0x2400/0x2800 → win_lo/win_hi update after each CALC; bin_shift 11 → 7 → 3; stage 0 → 1 → 2; tof_valid once.
3. Stub returns THminus = 0x3000, THpositive = 0x2000 at stage 0 → tof_valid with err = 1, no further passes.
4. abort during ACCUM of stage 1 → IDLE next cycle, busy = 0, no tof_valid; subsequent start restarts at stage 0, full window.
5. start pulsed while busy; start + abort in the same cycle from IDLE; peak_valid during ACCUM → all ignored.
6. SIFH_PEAK_TIMEOUT_EN with PEAK_TIMEOUT=10, no peak_valid → tof_valid with err = 1 exactly 10 cycles after PEAK entry; without the macro → busy stays 1.
